// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional write-to-read bypass is enabled by defining REGFILE_MP_BYPASS_EN.
package regfile_mp_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  // Low bit of port 'port' inside a flattened bus of 'width'-bit fields
  function automatic int lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_mp_sb.sv
// Issue-stage scoreboard: one pending bit per register, set by issue, cleared by writeback.
// With REGFILE_MP_BYPASS_EN, a register being written (and not re-issued) reads as not pending.
module regfile_mp_sb
  import regfile_mp_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]    rpend
);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [NRD-1:0]   byp_clr;

  // Clears are applied first so a same-cycle issue to the same register wins
  always_comb begin
    pend_d = pend_q;
    if (run) begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i]) pend_d[wa[lo(i, AW) +: AW]] = 1'b0;
      end
      if (iss_valid && iss_rd != '0) pend_d[iss_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  always_comb begin
    byp_clr = '0;
`ifdef REGFILE_MP_BYPASS_EN
    for (int j = 0; j < NRD; j++) begin
      for (int i = 0; i < NWR; i++) begin
        if (run && we[i] && wa[lo(i, AW) +: AW] == ra[lo(j, AW) +: AW] &&
            !(iss_valid && iss_rd == ra[lo(j, AW) +: AW]))
          byp_clr[j] = 1'b1;
      end
    end
`else
    byp_clr = '0;
`endif
  end

  always_comb begin
    rpend = '0;
    for (int j = 0; j < NRD; j++) begin
      rpend[j] = run && pend_q[ra[lo(j, AW) +: AW]] && !byp_clr[j];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with post-reset clear sequencer and pending scoreboard.
// Define REGFILE_MP_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rpend,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd
);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            run;

  assign run   = (state_q == RUN);
  assign ready = ready_q;

  // Clear sequencer walks registers 1..NREGS-1, then hands over to RUN
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    if (state_q == CLEAR) begin
      if (clr_idx_q == AW'(NREGS - 1)) begin
        state_d = RUN;
        ready_d = 1'b1;
      end else begin
        clr_idx_d = clr_idx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Ascending port order lets the highest-index writer win a conflict
  always_comb begin
    regs_d = regs_q;
    if (!run) begin
      regs_d[clr_idx_q] = '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && wa[lo(i, AW) +: AW] != '0)
          regs_d[wa[lo(i, AW) +: AW]] = wd[lo(i, XLEN) +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) regs_q <= regs_d;
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < NRD; j++) begin
      if (ra[lo(j, AW) +: AW] != '0)
        rdata[lo(j, XLEN) +: XLEN] = regs_q[ra[lo(j, AW) +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
      for (int i = 0; i < NWR; i++) begin
        if (run && we[i] && ra[lo(j, AW) +: AW] != '0 &&
            wa[lo(i, AW) +: AW] == ra[lo(j, AW) +: AW])
          rdata[lo(j, XLEN) +: XLEN] = wd[lo(i, XLEN) +: XLEN];
      end
`else
      rdata[lo(j, XLEN) +: XLEN] = rdata[lo(j, XLEN) +: XLEN];
`endif
    end
  end

  regfile_mp_sb #(
    .NREGS(NREGS),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .we       (we),
    .wa       (wa),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .ra       (ra),
    .rpend    (rpend)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, corner sequences and random traffic.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ready;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rpend;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mregs [NREGS];
  bit          mpend [NREGS];

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  ra0, ra1;
    logic [31:0] er0, er1;
    logic        ep0, ep1;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .ra       (ra),
    .rdata    (rdata),
    .rpend    (rpend),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural view: register value, optionally overridden by a same-cycle write
  function automatic logic [31:0] modelRdata(input int j);
    logic [4:0]  a;
    logic [31:0] v;
    a = ra[j*AW +: AW];
    if (a == 0) return 32'h0;
    v = mregs[a];
`ifdef REGFILE_MP_BYPASS_EN
    for (int i = 0; i < NWR; i++)
      if (we[i] && wa[i*AW +: AW] == a) v = wd[i*XLEN +: XLEN];
`endif
    return v;
  endfunction

  function automatic logic modelRpend(input int j);
    logic [4:0] a;
    logic       p;
    a = ra[j*AW +: AW];
    if (a == 0) return 1'b0;
    p = mpend[a];
`ifdef REGFILE_MP_BYPASS_EN
    for (int i = 0; i < NWR; i++)
      if (we[i] && wa[i*AW +: AW] == a && !(iss_valid && iss_rd == a)) p = 1'b0;
`endif
    return p;
  endfunction

  task automatic modelUpdate();
    for (int i = 0; i < NWR; i++) begin
      if (we[i] && wa[i*AW +: AW] != 0) mregs[wa[i*AW +: AW]] = wd[i*XLEN +: XLEN];
      if (we[i]) mpend[wa[i*AW +: AW]] = 1'b0;
    end
    if (iss_valid && iss_rd != 0) mpend[iss_rd] = 1'b1;
  endtask

  task automatic modelReset();
    for (int r = 0; r < NREGS; r++) begin
      mregs[r] = 32'h0;
      mpend[r] = 1'b0;
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic iv,
                       input logic [4:0] ird, input logic [4:0] r0, input logic [4:0] r1);
    we = w; wa = {a1, a0}; wd = {d1, d0};
    iss_valid = iv; iss_rd = ird; ra = {r1, r0};
  endtask

  task automatic idleInputs();
    we = '0;
    iss_valid = 1'b0;
  endtask

  task automatic checkModel(input string tag);
    for (int j = 0; j < NRD; j++) begin
      checkOutput($sformatf("%s rdata%0d", tag, j), rdata[j*XLEN +: XLEN], modelRdata(j));
      checkOutput($sformatf("%s rpend%0d", tag, j), {31'b0, rpend[j]}, {31'b0, modelRpend(j)});
    end
  endtask

  task automatic waitReady(output int cycles);
    cycles = 0;
    while (ready !== 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int k);
    @(negedge clk);
    drive(v.we, v.wa0, v.wa1, v.wd0, v.wd1, v.iv, v.ird, v.ra0, v.ra1);
    @(posedge clk);
    modelUpdate();
    #1;
    idleInputs();
    #1;
    checkOutput($sformatf("vec%0d rdata0", k), rdata[31:0], v.er0);
    checkOutput($sformatf("vec%0d rdata1", k), rdata[63:32], v.er1);
    checkOutput($sformatf("vec%0d rpend0", k), {31'b0, rpend[0]}, {31'b0, v.ep0});
    checkOutput($sformatf("vec%0d rpend1", k), {31'b0, rpend[1]}, {31'b0, v.ep1});
  endtask

  initial begin
    int          c;
    logic [31:0] exp_byp;

    tbl[0] = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[1] = '{2'b01, 5'd0,  5'd0,  32'h00001234, 32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2] = '{2'b11, 5'd7,  5'd7,  32'h11111111, 32'h22222222, 1'b0, 5'd0,  5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[3] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd9,  5'd9,  5'd7,  32'h0,        32'h22222222, 1'b1, 1'b0};
    tbl[4] = '{2'b01, 5'd9,  5'd0,  32'h00000099, 32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h00000099, 32'h00000099, 1'b0, 1'b0};
    tbl[5] = '{2'b10, 5'd0,  5'd9,  32'h0,        32'h00000077, 1'b1, 5'd9,  5'd9,  5'd7,  32'h00000077, 32'h22222222, 1'b1, 1'b0};
    tbl[6] = '{2'b10, 5'd0,  5'd9,  32'h0,        32'h00000088, 1'b0, 5'd0,  5'd9,  5'd9,  32'h00000088, 32'h00000088, 1'b0, 1'b0};
    tbl[7] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd0,  5'd0,  5'd9,  32'h0,        32'h00000088, 1'b0, 1'b0};
    tbl[8] = '{2'b11, 5'd12, 5'd13, 32'hCAFE0000, 32'h00000013, 1'b0, 5'd0,  5'd12, 5'd13, 32'hCAFE0000, 32'h00000013, 1'b0, 1'b0};
    tbl[9] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd13, 5'd13, 5'd12, 32'h00000013, 32'hCAFE0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    modelReset();

    // Reset, then the clear sequence must take exactly NREGS-1 edges
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ready", {31'b0, ready}, 32'h0);
    checkOutput("reset rpend", {30'b0, rpend}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    waitReady(c);
    checkOutput("clear cycles", c, 32'd31);

    for (int r = 1; r < NREGS; r++) begin
      ra = {5'(NREGS - r), 5'(r)};
      #1;
      checkOutput($sformatf("cleared x%0d", r), rdata[31:0], 32'h0);
      checkOutput($sformatf("cleared rpend x%0d", r), {31'b0, rpend[0]}, 32'h0);
    end

    for (int k = 0; k < 10; k++) applyStimulus(tbl[k], k);

    // Same-cycle write and read of x3
    @(negedge clk);
    drive(2'b01, 5'd3, 5'd0, 32'hA5A5A5A5, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
`ifdef REGFILE_MP_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = mregs[3];
`endif
    #1;
    checkOutput("same-cycle x3", rdata[31:0], exp_byp);
    @(posedge clk);
    modelUpdate();
    #1;
    idleInputs();
    #1;
    checkOutput("next-cycle x3", rdata[31:0], 32'hA5A5A5A5);

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we        = 2'($urandom_range(0, 3));
      wa        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wd        = {32'($urandom), 32'($urandom)};
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      ra        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      checkModel($sformatf("rand%0d", n));
      @(posedge clk);
      modelUpdate();
    end

    // Mid-run reset wipes data and pending state; writes during CLEAR are ignored
    @(negedge clk);
    drive(2'b01, 5'd4, 5'd0, 32'h00000055, 32'h0, 1'b1, 5'd6, 5'd4, 5'd6);
    @(posedge clk);
    modelUpdate();
    #1;
    idleInputs();
    #1;
    checkOutput("x4 before reset", rdata[31:0], 32'h00000055);
    checkOutput("x6 pend before reset", {31'b0, rpend[1]}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready after mid reset", {31'b0, ready}, 32'h0);
    checkOutput("rpend after mid reset", {30'b0, rpend}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    drive(2'b01, 5'd2, 5'd0, 32'h00000BAD, 32'h0, 1'b1, 5'd2, 5'd4, 5'd2);
    @(posedge clk);
    #1;
    idleInputs();
    waitReady(c);
    checkOutput("re-clear cycles", c, 32'd20);
    ra = {5'd2, 5'd4};
    #1;
    checkOutput("x4 after re-clear", rdata[31:0], 32'h0);
    checkOutput("x2 write ignored in clear", rdata[63:32], 32'h0);
    checkOutput("x2 issue ignored in clear", {31'b0, rpend[1]}, 32'h0);
    ra = {5'd6, 5'd4};
    #1;
    checkOutput("x6 pend cleared", {31'b0, rpend[1]}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
